// File: rtl/nibble_add_sched.sv
// Two-requester adder that time-shares one 4-bit slice, one nibble per clock, with round-robin arbitration.
// Optional subtract mode (a - b - cin) is enabled by defining NIBBLE_ADD_SCHED_SUB_EN.
module nibble_add_sched #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  output logic                 req0_ready,
  output logic                 req1_ready,
  input  logic [4*NIBBLES-1:0] req0_a,
  input  logic [4*NIBBLES-1:0] req0_b,
  input  logic [4*NIBBLES-1:0] req1_a,
  input  logic [4*NIBBLES-1:0] req1_b,
  input  logic                 req0_cin,
  input  logic                 req1_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_id
`ifdef NIBBLE_ADD_SCHED_SUB_EN
  ,
  input  logic                 req0_sub,
  input  logic                 req1_sub
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic            armed_q, armed_d;
  logic            last_q, last_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            op_id_q, op_id_d;
  logic            cout_q, cout_d;
  logic            id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            grant0, grant1, sub0, sub1;
  logic [3:0]      a_nib, b_nib, s_nib;
  logic            c_nib;

`ifdef NIBBLE_ADD_SCHED_SUB_EN
  assign sub0 = req0_sub;
  assign sub1 = req1_sub;
`else
  assign sub0 = 1'b0;
  assign sub1 = 1'b0;
`endif

  // Tie goes to whichever requester was not served last (last_q = 1 means req1).
  assign grant0     = req0_valid && (!req1_valid || last_q);
  assign grant1     = req1_valid && !grant0;
  assign req0_ready = armed_q && (state_q == IDLE) && grant0;
  assign req1_ready = armed_q && (state_q == IDLE) && grant1;

  assign a_nib           = a_q[{cnt_q, 2'b00} +: 4];
  assign b_nib           = b_q[{cnt_q, 2'b00} +: 4];
  assign {c_nib, s_nib}  = 5'(a_nib) + 5'(b_nib) + 5'(carry_q);

  // NOTE: combinational blocks use blocking '=' and assign every output a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    armed_d = 1'b1;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    op_id_d = op_id_q;
    cout_d  = cout_q;
    id_d    = id_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          // Subtraction is a + ~b + ~cin, so fold the inversion in at capture time.
          a_d     = req1_ready ? req1_a : req0_a;
          b_d     = req1_ready ? (sub1 ? ~req1_b : req1_b) : (sub0 ? ~req0_b : req0_b);
          carry_d = req1_ready ? (req1_cin ^ sub1) : (req0_cin ^ sub0);
          op_id_d = req1_ready;
          last_d  = req1_ready;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d[{cnt_q, 2'b00} +: 4] = s_nib;
        carry_d = c_nib;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_NIB) begin
          sum_d   = acc_d;
          cout_d  = c_nib;
          id_d    = op_id_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the operand and work registers are reset along with control so no X ever reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      op_id_q <= 1'b0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      op_id_q <= op_id_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Randomized bench for nibble_add_sched against a whole-word arithmetic reference with round-robin bookkeeping.
// Define NIBBLE_ADD_SCHED_SUB_EN to also exercise subtract mode.
module tb_nibble_add_sched;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_cin, req1_cin, req0_sub, req1_sub;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [W-1:0] rsp_sum;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit m_last = 1'b1;

`ifdef NIBBLE_ADD_SCHED_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  nibble_add_sched #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_cin(req0_cin), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
`ifdef NIBBLE_ADD_SCHED_SUB_EN
    , .req0_sub(req0_sub), .req1_sub(req1_sub)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input bit cin, input bit sub);
    logic [W:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(!cin);
    else     r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic scramble();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_a = W'($urandom); req0_b = W'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom);
    req0_cin = 1'($urandom); req1_cin = 1'($urandom);
    req0_sub = SUB_EN & 1'($urandom); req1_sub = SUB_EN & 1'($urandom);
  endtask

  // Called at a falling edge with the DUT idle; returns just after the falling edge following the handshake.
  task automatic op(input bit v0, input bit v1,
                    input logic [W-1:0] a0, input logic [W-1:0] b0, input bit c0, input bit s0,
                    input logic [W-1:0] a1, input logic [W-1:0] b1, input bit c1, input bit s1,
                    input int hold);
    bit e0, e1;
    logic [W:0] exp;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req0_cin = c0; req0_sub = s0;
    req1_a = a1; req1_b = b1; req1_cin = c1; req1_sub = s1;
    rsp_ready = 1'b0;
    e0 = v0 && (!v1 || m_last);
    e1 = v1 && !e0;
    exp = e1 ? model(a1, b1, c1, s1) : model(a0, b0, c0, s0);
    #1;
    check("idle_ready0", req0_ready, e0);
    check("idle_ready1", req1_ready, e1);
    @(posedge clk);
    m_last = e1;
    @(negedge clk);
    for (int k = 1; k <= NIBBLES; k++) begin
      scramble();
      #1;
      check("calc_rsp_valid", rsp_valid, 1'b0);
      check("calc_readies", {req0_ready, req1_ready}, 2'b00);
      @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      scramble();
      rsp_ready = (h == hold);
      #1;
      check("done_rsp_valid", rsp_valid, 1'b1);
      check("done_sum", rsp_sum, exp[W-1:0]);
      check("done_cout", rsp_cout, exp[W]);
      check("done_id", rsp_id, e1);
      check("done_readies", {req0_ready, req1_ready}, 2'b00);
      if (h < hold) @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("post_rsp_valid", rsp_valid, 1'b0);
    check("post_sum_kept", rsp_sum, exp[W-1:0]);
    check("post_id_kept", rsp_id, e1);
  endtask

  task automatic rand_op(input int hold);
    bit v0, v1;
    v0 = 1'($urandom);
    v1 = v0 ? 1'($urandom) : 1'b1;
    op(v0, v1, rand_word(), rand_word(), 1'($urandom), SUB_EN & 1'($urandom),
               rand_word(), rand_word(), 1'($urandom), SUB_EN & 1'($urandom), hold);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    scramble();
    #1;
    check("rst_readies", {req0_ready, req1_ready}, 2'b00);
    check("rst_rsp", {rsp_valid, rsp_cout, rsp_id}, 3'b000);
    check("rst_sum", rsp_sum, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_readies_held", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Directed vectors from the datasheet examples.
    op(1, 0, 16'h1234, 16'h0FFF, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    op(0, 1, 16'h0, 16'h0, 0, 0, 16'hFFFF, 16'h0001, 1, 0, 0);

    // Both valid held: alternation and 6-cycle throughput.
    for (int i = 0; i < 4; i++) begin
      t0 = cyc;
      op(1, 1, rand_word(), rand_word(), 1'($urandom), 0,
               rand_word(), rand_word(), 1'($urandom), 0, 0);
      check("op_cycles", 64'(cyc - t0), 64'd6);
    end

    op(1, 1, rand_word(), rand_word(), 1, 0, rand_word(), rand_word(), 0, 0, 5);

    if (SUB_EN) op(1, 0, 16'h0005, 16'h0007, 0, 1, 16'h0, 16'h0, 0, 0, 0);

    for (int i = 0; i < 40; i++) rand_op(int'($urandom_range(0, 2)));

    // Reset in the second CALC cycle drops the operation.
    scramble();
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp", {rsp_valid, rsp_cout, rsp_id}, 3'b000);
    check("midrst_sum", rsp_sum, '0);
    check("midrst_readies", {req0_ready, req1_ready}, 2'b00);
    m_last = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_rel_readies", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int k = 0; k < NIBBLES + 2; k++) begin
      #1;
      check("midrst_no_rsp", rsp_valid, 1'b0);
      @(negedge clk);
    end
    op(1, 1, rand_word(), rand_word(), 0, 0, rand_word(), rand_word(), 1, 0, 0);
    op(1, 1, rand_word(), rand_word(), 1, 0, rand_word(), rand_word(), 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
